// File: rtl/acc_mlp_pkg.sv
// Shared types and helpers for the time-multiplexed 2-layer perceptron:
// FSM state encoding, activation (shift + clamp) and config address map.
package acc_mlp_pkg;

   typedef enum logic [1:0] {S_IDLE, S_L1, S_L2, S_DONE} state_t;

   // Floor shift followed by clamping to [ymin, ymax].
   function automatic logic signed [31:0] act(input logic signed [63:0] a,
                                              input int shift,
                                              input int ymin,
                                              input int ymax);
      logic signed [63:0] t;
      t = a >>> shift;
      if (t < 64'(ymin))      return ymin;
      else if (t > 64'(ymax)) return ymax;
      else                    return t[31:0];
   endfunction

   function automatic int hw_addr(input int h, input int i, input int nin);
      return h * nin + i;
   endfunction

   function automatic int ow_addr(input int h, input int nin, input int nhid);
      return nhid * nin + h;
   endfunction

   function automatic int bias_addr(input int n, input int nin, input int nhid);
      return nhid * nin + nhid + n;
   endfunction

endpackage

// File: rtl/acc_mac_act.sv
// Single shared MAC: selects bias or running sum as the base, adds the
// full-precision product, and applies the activation to the result.
module acc_mac_act
   import acc_mlp_pkg::*;
#(
   parameter int DW    = 8,
   parameter int BW    = 16,
   parameter int ACCW  = 24,
   parameter int SHIFT = 7,
   parameter int YMIN  = -127,
   parameter int YMAX  = 127
) (
   input  logic                   first,
   input  logic signed [ACCW-1:0] acc,
   input  logic signed [BW-1:0]   bias,
   input  logic signed [DW-1:0]   w,
   input  logic signed [DW-1:0]   d,
   output logic signed [ACCW-1:0] sum,
   output logic signed [DW-1:0]   y
);

   logic signed [2*DW-1:0] prod;
   logic signed [ACCW-1:0] base;

   assign prod = w * d;
   assign base = first ? ACCW'(bias) : acc;
   assign sum  = base + ACCW'(prod);
   assign y    = DW'(act(64'(sum), SHIFT, YMIN, YMAX));

endmodule

// File: rtl/acc_mlp_seq.sv
// Sequential 2-layer perceptron: NIN inputs, NHID hidden neurons, one output,
// one MAC per cycle, run-time weights, valid/ready on both sides.
module acc_mlp_seq
   import acc_mlp_pkg::*;
#(
   parameter int DW    = 8,
   parameter int NIN   = 4,
   parameter int NHID  = 2,
   parameter int BW    = 16,
   parameter int ACCW  = 24,
   parameter int SHIFT = 7,
   parameter int YMIN  = -127,
   parameter int YMAX  = 127
) (
   input  logic                 clk,
   input  logic                 arst_n,
   input  logic [NIN*DW-1:0]    x,
   input  logic                 valid,
   output logic                 ready,
   output logic signed [DW-1:0] y,
   output logic                 valid_out,
   input  logic                 ready_out,
   input  logic                 cfg_we,
   input  logic [7:0]           cfg_addr,
   input  logic [BW-1:0]        cfg_data,
   output logic                 busy
);

   localparam int NW = NHID * NIN;
   localparam int CW = $clog2((NIN > NHID) ? NIN : NHID) + 1;

   state_t                 state;
   logic [CW-1:0]          nrn, idx;
   logic signed [ACCW-1:0] acc;
   logic signed [DW-1:0]   xr    [NIN];
   logic signed [DW-1:0]   hid   [NHID];
   logic signed [DW-1:0]   w_mem [NW];
   logic signed [DW-1:0]   v_mem [NHID];
   logic signed [BW-1:0]   b_mem [NHID+1];

   logic                   first;
   logic signed [BW-1:0]   bias_sel;
   logic signed [DW-1:0]   w_sel, d_sel, act_y;
   logic signed [ACCW-1:0] sum;

   assign ready = (state == S_IDLE) || (state == S_DONE && ready_out);
   assign busy  = (state != S_IDLE);

   // Operand mux: L1 walks w[nrn][idx]*x[idx], L2 walks v[idx]*hid[idx].
   always_comb begin
      first    = (idx == '0);
      bias_sel = b_mem[NHID];
      w_sel    = '0;
      d_sel    = '0;
      if (state == S_L1) begin
         bias_sel = '0;
         for (int h = 0; h < NHID; h++) begin
            if (nrn == CW'(h)) begin
               bias_sel = b_mem[h];
               for (int i = 0; i < NIN; i++)
                  if (idx == CW'(i)) w_sel = w_mem[h*NIN+i];
            end
         end
         for (int i = 0; i < NIN; i++)
            if (idx == CW'(i)) d_sel = xr[i];
      end else begin
         for (int h = 0; h < NHID; h++) begin
            if (idx == CW'(h)) begin
               w_sel = v_mem[h];
               d_sel = hid[h];
            end
         end
      end
   end

   acc_mac_act #(
      .DW(DW), .BW(BW), .ACCW(ACCW), .SHIFT(SHIFT), .YMIN(YMIN), .YMAX(YMAX)
   ) u_mac (
      .first(first), .acc(acc), .bias(bias_sel), .w(w_sel), .d(d_sel),
      .sum(sum), .y(act_y)
   );

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         for (int k = 0; k < NW; k++)     w_mem[k] <= '0;
         for (int h = 0; h < NHID; h++)   v_mem[h] <= '0;
         for (int n = 0; n <= NHID; n++)  b_mem[n] <= '0;
      end else if (cfg_we && state == S_IDLE) begin
         for (int h = 0; h < NHID; h++) begin
            for (int i = 0; i < NIN; i++)
               if (int'(cfg_addr) == hw_addr(h, i, NIN)) w_mem[h*NIN+i] <= cfg_data[DW-1:0];
            if (int'(cfg_addr) == ow_addr(h, NIN, NHID)) v_mem[h] <= cfg_data[DW-1:0];
         end
         for (int n = 0; n <= NHID; n++)
            if (int'(cfg_addr) == bias_addr(n, NIN, NHID)) b_mem[n] <= cfg_data;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state     <= S_IDLE;
         nrn       <= '0;
         idx       <= '0;
         acc       <= '0;
         y         <= '0;
         valid_out <= 1'b0;
         for (int i = 0; i < NIN; i++)  xr[i]  <= '0;
         for (int h = 0; h < NHID; h++) hid[h] <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (valid) begin
                  for (int i = 0; i < NIN; i++) xr[i] <= x[i*DW +: DW];
                  nrn   <= '0;
                  idx   <= '0;
                  state <= S_L1;
               end
            end
            S_L1: begin
               acc <= sum;
               if (idx == CW'(NIN-1)) begin
                  for (int h = 0; h < NHID; h++)
                     if (nrn == CW'(h)) hid[h] <= act_y;
                  idx <= '0;
                  if (nrn == CW'(NHID-1)) begin
                     nrn   <= '0;
                     state <= S_L2;
                  end else begin
                     nrn <= nrn + 1'b1;
                  end
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            S_L2: begin
               acc <= sum;
               if (idx == CW'(NHID-1)) begin
                  idx       <= '0;
                  y         <= act_y;
                  valid_out <= 1'b1;
                  state     <= S_DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            S_DONE: begin
               // Result holds until the sink takes it; a waiting input is taken on the same edge.
               if (ready_out) begin
                  valid_out <= 1'b0;
                  if (valid) begin
                     for (int i = 0; i < NIN; i++) xr[i] <= x[i*DW +: DW];
                     nrn   <= '0;
                     idx   <= '0;
                     state <= S_L1;
                  end else begin
                     state <= S_IDLE;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_acc_mlp_seq.sv
// Directed bench for acc_mlp_seq at default parameters with hand-computed
// expected hidden values, outputs, latencies and handshake behaviour.
module tb_acc_mlp_seq;

   logic              clk = 1'b0;
   logic              arst_n;
   logic [31:0]       x;
   logic              valid;
   logic              ready;
   logic signed [7:0] y;
   logic              valid_out;
   logic              ready_out;
   logic              cfg_we;
   logic [7:0]        cfg_addr;
   logic [15:0]       cfg_data;
   logic              busy;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   acc_mlp_seq dut (
      .clk(clk), .arst_n(arst_n), .x(x), .valid(valid), .ready(ready),
      .y(y), .valid_out(valid_out), .ready_out(ready_out),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .busy(busy)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] pack(input int a, input int b, input int c, input int d);
      return {8'(d), 8'(c), 8'(b), 8'(a)};
   endfunction

   task automatic cfg(input int a, input int d);
      @(negedge clk);
      cfg_we   = 1'b1;
      cfg_addr = 8'(a);
      cfg_data = 16'(d);
      @(negedge clk);
      cfg_we   = 1'b0;
   endtask

   task automatic load(input int wh [8], input int vv [2], input int bb [3]);
      for (int k = 0; k < 8; k++) cfg(k, wh[k]);
      for (int k = 0; k < 2; k++) cfg(8 + k, vv[k]);
      for (int k = 0; k < 3; k++) cfg(10 + k, bb[k]);
   endtask

   // Presents one input and returns #1 after its accept edge.
   task automatic start(input string tag, input logic [31:0] xv);
      @(negedge clk);
      chk({tag, "_ready"}, int'(ready), 1);
      x     = xv;
      valid = 1'b1;
      @(posedge clk);
      #1 valid = 1'b0;
      chk({tag, "_busy"}, int'(busy), 1);
   endtask

   task automatic wait_out(input string tag, input int lat_exp, input bit leave);
      int lat;
      lat = 0;
      while (valid_out !== 1'b1 && lat < 40) begin
         @(posedge clk);
         #1 lat++;
      end
      chk({tag, "_lat"}, lat, lat_exp);
      if (leave) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int w64 [8]  = '{64, 64, 64, 64, 64, 64, 64, 64};
      int v32 [2]  = '{32, 32};
      int w127 [8] = '{127, 127, 127, 127, 127, 127, 127, 127};
      int v127 [2] = '{127, 127};
      int b0 [3]   = '{0, 0, 0};
      int wt [8]   = '{-115, 1, -105, 16, 103, -22, 32, -56};
      int vt [2]   = '{75, -85};
      int bt [3]   = '{12571, -8139, 10182};
      int y_hold;

      arst_n = 1'b0; x = '0; valid = 1'b0; ready_out = 1'b1;
      cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
      repeat (2) @(negedge clk);
      chk("por_y", int'(y), 0);
      chk("por_vout", int'(valid_out), 0);
      chk("por_busy", int'(busy), 0);
      chk("por_ready", int'(ready), 1);
      arst_n = 1'b1;

      // Reset in the middle of L1
      load(w64, v32, b0);
      start("mid", pack(1, 1, 1, 1));
      repeat (3) @(posedge clk);
      #1 arst_n = 1'b0;
      #2;
      chk("rst_y", int'(y), 0);
      chk("rst_vout", int'(valid_out), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_ready", int'(ready), 1);
      @(negedge clk);
      arst_n = 1'b1;
      start("zero", pack(5, 5, 5, 5));
      wait_out("zero", 10, 1'b1);
      chk("zero_y", int'(y), 0);

      // Positive and negative path
      load(w64, v32, b0);
      start("pos", pack(2, 2, 2, 2));
      wait_out("pos", 10, 1'b0);
      chk("pos_hid0", int'(dut.hid[0]), 4);
      chk("pos_hid1", int'(dut.hid[1]), 4);
      chk("pos_y", int'(y), 2);
      @(posedge clk);
      #1;
      start("neg", pack(-2, -2, -2, -2));
      wait_out("neg", 10, 1'b1);
      chk("neg_y", int'(y), -2);

      // Floor rounding with output bias -1
      cfg(12, -1);
      start("floor", pack(2, 2, 2, 2));
      wait_out("floor", 10, 1'b0);
      chk("floor_acc", int'(dut.acc), 255);
      chk("floor_y", int'(y), 1);
      @(posedge clk);
      #1;

      // Saturation at the low clamp
      load(w127, v127, b0);
      start("satlo", pack(-128, -128, -128, -128));
      wait_out("satlo", 10, 1'b0);
      chk("satlo_hid0", int'(dut.hid[0]), -127);
      chk("satlo_hid1", int'(dut.hid[1]), -127);
      chk("satlo_y", int'(y), -127);
      @(posedge clk);
      #1;

      // Bias-dominated mixed case, high clamp on the output
      load(wt, vt, bt);
      start("sathi", pack(0, 0, 0, 0));
      wait_out("sathi", 10, 1'b0);
      chk("sathi_hid0", int'(dut.hid[0]), 98);
      chk("sathi_hid1", int'(dut.hid[1]), -64);
      chk("sathi_y", int'(y), 127);
      @(posedge clk);
      #1;

      // Backpressure, then back-to-back accept from DONE
      load(w64, v32, b0);
      ready_out = 1'b0;
      start("bp", pack(2, 2, 2, 2));
      wait_out("bp", 10, 1'b0);
      y_hold = int'(y);
      chk("bp_y0", y_hold, 2);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp_y_hold", int'(y), 2);
         chk("bp_vout_hold", int'(valid_out), 1);
         chk("bp_ready_low", int'(ready), 0);
         x     = pack(9, 9, 9, 9);
         valid = c[0];
      end
      @(negedge clk);
      x         = pack(-2, -2, -2, -2);
      valid     = 1'b1;
      ready_out = 1'b1;
      #1 chk("b2b_ready", int'(ready), 1);
      @(posedge clk);
      #1 valid = 1'b0;
      chk("b2b_vout_drop", int'(valid_out), 0);
      chk("b2b_busy", int'(busy), 1);
      wait_out("b2b", 10, 1'b1);
      chk("b2b_y", int'(y), -2);

      // Config lockout: out-of-map write while idle, in-map write during L1
      cfg(200, 5);
      start("lock", pack(2, 2, 2, 2));
      cfg_we   = 1'b1;
      cfg_addr = 8'd0;
      cfg_data = 16'd5;
      @(posedge clk);
      #1 cfg_we = 1'b0;
      wait_out("lock", 9, 1'b1);
      chk("lock_y", int'(y), 2);
      start("lock2", pack(2, 2, 2, 2));
      wait_out("lock2", 10, 1'b1);
      chk("lock2_y", int'(y), 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
